// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V core: sequences the shared memory
// port, ALU and register file, and drives the datapath enables and mux selects.

module alu_decoder (
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_funct7,
    output logic [2:0] o_alu_control
);

    // ALU operation select from the FSM's coarse alu_op and the instruction fields
    always_comb begin
        o_alu_control = 3'b000;
        case (i_alu_op)
            2'b00: o_alu_control = 3'b000;
            2'b01: o_alu_control = 3'b001;
            2'b10: begin
                case (i_funct3)
                    // only R-type (op[5]=1) with funct7b5=1 subtracts; addi never does
                    3'b000: begin
                        if (i_funct7 == 2'b11) begin
                            o_alu_control = 3'b001;
                        end else begin
                            o_alu_control = 3'b000;
                        end
                    end
                    3'b010:  o_alu_control = 3'b101;
                    3'b110:  o_alu_control = 3'b011;
                    3'b111:  o_alu_control = 3'b010;
                    default: o_alu_control = 3'b000;
                endcase
            end
            default: o_alu_control = 3'b000;
        endcase
    end

endmodule

module multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     r_state;
    logic       r_illegal;
    state_t     w_next_state;
    logic       w_set_illegal;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;

    // State register and sticky unsupported-opcode flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= r_illegal | w_set_illegal;
        end
    end

    // Next-state logic and Moore outputs of the current state
    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_op      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_update  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // precompute the branch target from OldPC + ImmExt
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_ITYPE:     w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default: begin
                        w_set_illegal = 1'b1;
                        if (ILLEGAL_HALT) begin
                            w_next_state = S_HALT;
                        end else begin
                            w_next_state = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                if (op == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else begin
                    w_next_state = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_alu_op     = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_LW:    imm_src = 2'b00;
            OP_ITYPE: imm_src = 2'b00;
            OP_SW:    imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7      ({op[5], funct7b5}),
        .o_alu_control (alu_control)
    );

    // state changes are gated off for the whole reset pulse, not just its first edge
    assign pc_write   = ~reset & (w_pc_update | (w_branch & zero));
    assign mem_write  = ~reset & w_mem_write;
    assign reg_write  = ~reset & w_reg_write;
    assign ir_write   = ~reset & w_ir_write;
    assign adr_src    = w_adr_src;
    assign result_src = w_result_src;
    assign alu_src_a  = w_alu_src_a;
    assign alu_src_b  = w_alu_src_b;
    assign illegal    = r_illegal;
    assign state      = r_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle variant of the RISC-V core.
- Sequences the shared datapath: one memory port, one ALU and the register file.
- Decodes op/funct fields and steps each instruction through FETCH/DECODE/execute/writeback states.
- Generates the datapath enables and mux selects, and instantiates the existing alu_decoder to produce alu_control.

Parameters:
- ILLEGAL_HALT, 0: 1 = an unsupported opcode parks the FSM in HALT until reset; 0 = the FSM returns to FETCH.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- op  in  7  instruction opcode (instr[6:0])
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction/old-PC register enable
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU result
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- imm_src  out  2  immediate format
- reg_write  out  1  register file write enable
- alu_control  out  3  ALU operation, from alu_decoder
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state encoding, for debug

Behaviour:
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, HALT=11.

Reset:
- While reset is high: state=FETCH and illegal=0, asynchronously.
- While reset is high, pc_write, mem_write, reg_write and ir_write are forced 0.
- All other outputs show their FETCH values during reset.
- Deasserting reset makes the first clocked FETCH cycle live.
- Reset mid-instruction abandons the instruction; no partial write occurs after the assert.

Transitions:
- FETCH -> DECODE.
- DECODE on op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> illegal set to 1, then HALT if ILLEGAL_HALT=1, else FETCH.
- MEMADR -> MEMREAD if op=lw, else MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI and JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- HALT -> HALT.

Moore outputs per state; any output not listed is 0:
- FETCH: ir_write=1, pc_update=1, alu_src_b=10, result_src=10, alu_op=00.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute).
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
- MEMREAD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, pc_update=1.
- HALT: every enable 0.

Combinational rules:
- pc_write = pc_update | (branch & zero).
- imm_src, decoded from op in every state: lw and I-type 00, sw 01, beq 10, jal 11, anything else 00.
- alu_decoder inputs: alu_op, funct3, and funct7 = {op[5], funct7b5}. Subtract only for R-type with funct7b5=1.
- ALU codes: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Latency in cycles, FETCH to the next FETCH:
- lw 5; sw, R-type, I-type and jal 4; beq 3.

Sticky flag:
- illegal is cleared only by reset.

Test Plan:
- Reset high mid-EXECUTER -> state=0 immediately; write enables 0. Release reset -> FETCH has ir_write=1, pc_write=1, alu_src_b=10.
- lw (op=0000011) -> states 0,1,2,3,4; MEMREAD adr_src=1; MEMWB reg_write=1, result_src=01; imm_src=00.
- sw (op=0100011) -> states 0,1,2,5; mem_write=1 only in state 5; imm_src=01; reg_write never 1.
- R-type, op=0110011, funct3=000: funct7b5=1 -> EXECUTER alu_control=001; funct7b5=0 -> 000. I-type (op=0010011) with funct7b5=1 -> 000.
- beq (op=1100011): zero=1 -> pc_write=1 in state 9; zero=0 -> pc_write=0. Either way back to FETCH after 3 cycles.
- op=1111111:
  - ILLEGAL_HALT=0: illegal=1 and FETCH next.
  - ILLEGAL_HALT=1: state=11 held, with all enables 0.
  - In both cases illegal stays 1 until reset.
